pipe_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline (IF ID EX MEM WB).

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_div_seq.sv | 37 +++
 rtl/pipe_ctrl.sv | 64 ++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline stall/flush scheduler
package pipe_ctrl_pkg;
  typedef enum logic {PC_IDLE = 1'b0, PC_DIV = 1'b1} div_state_t;
  localparam int DIV_LAT_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int DIV_CNT_W = 8;
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_mem;
    logic flush_wb;
    logic redirect;
  } ctrl_t;
  localparam ctrl_t CTRL_MEMW = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mem: 1'b1,
                                  flush_wb: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_DIV = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, flush_mem: 1'b1,
                                 default: 1'b0};
  localparam ctrl_t CTRL_BR = '{redirect: 1'b1, flush_id: 1'b1, flush_ex: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LU = '{stall_if: 1'b1, stall_id: 1'b1, flush_ex: 1'b1, default: 1'b0};
endpackage

// File: rtl/pipe_div_seq.sv
// pipe_div_seq: divider occupancy sequencer (IDLE/DIV state, down-counter, busy/done)
module pipe_div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic done,
  output logic stall
);
  // counter hits zero in the done cycle, so the issue cycle plus DIV_LAT-1 more
  localparam logic [DIV_CNT_W-1:0] LOAD = DIV_CNT_W'(DIV_LAT - 2);
  div_state_t state, state_d;
  logic [DIV_CNT_W-1:0] cnt, cnt_d;
  logic issue, last;
  assign issue = state == PC_IDLE && start && !hold;
  assign last = state == PC_DIV && cnt == '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= PC_IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  always_comb begin
    state_d = issue ? PC_DIV : last ? PC_IDLE : state;
    cnt_d = issue ? LOAD : (state == PC_DIV && !last) ? cnt - 1'b1 : cnt;
  end
  assign busy = state == PC_DIV;
  assign done = last;
  assign stall = (busy && !last) || (state == PC_IDLE && start);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush scheduler; define PERF_CNT_EN to build the perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_use,
  input  logic             br_taken_EX,
  input  logic             div_start_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ack,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_MEM,
  output logic             flush_WB,
  output logic             redirect,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  logic memw, mem_wait, div_stall;
  ctrl_t ctrl;
  // an outstanding request keeps waiting until acked, independent of the DIV state
  assign mem_wait = (mem_req_MEM || memw) && !mem_ack;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) memw <= 1'b0;
    else memw <= mem_wait;
  pipe_div_seq #(.DIV_LAT(DIV_LAT)) u_div_seq (
    .clk  (clk),
    .rstn (rstn),
    .start(div_start_EX),
    .hold (mem_wait),
    .busy (div_busy),
    .done (div_done),
    .stall(div_stall)
  );
  // redirect only fires when EX advances, so a held branch redirects exactly once
  always_comb
    ctrl = mem_wait ? CTRL_MEMW : div_stall ? CTRL_DIV : br_taken_EX ? CTRL_BR :
           load_use ? CTRL_LU : '0;
  assign {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_MEM, flush_WB,
          redirect} = ctrl;
`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + CNT_W'(stall_IF);
      flush_count <= flush_count + CNT_W'(redirect);
    end
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (DIV_LAT=16)
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load_use = 1'b0, br_taken_EX = 1'b0, div_start_EX = 1'b0;
  logic mem_req_MEM = 1'b0, mem_ack = 1'b0;
  logic stall_IF, stall_ID, stall_EX, stall_MEM;
  logic flush_ID, flush_EX, flush_MEM, flush_WB;
  logic redirect, div_busy, div_done;
  logic [31:0] stall_cycles, flush_count;
  logic [8:0] obs;
  int errors = 0;
  int checks = 0;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110001000;
  localparam logic [8:0] DIVS = 9'b111000100;
  localparam logic [8:0] MEMS = 9'b111100010;
  localparam logic [8:0] BR   = 9'b000011001;
`ifdef PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS = 32'd3;
  localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  pipe_ctrl #(.DIV_LAT(16), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .load_use(load_use), .br_taken_EX(br_taken_EX),
    .div_start_EX(div_start_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM), .flush_WB(flush_WB),
    .redirect(redirect), .div_busy(div_busy), .div_done(div_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;
  assign obs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_MEM, flush_WB,
                redirect};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (obs !== NONE) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", obs, NONE); end
    checks++; if ({div_busy, div_done} !== 2'b00) begin errors++; $display("FAIL reset_div got=%b exp=00", {div_busy, div_done}); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
    cyc();
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (obs !== NONE || div_busy !== 1'b0) begin errors++; $display("FAIL post_reset got=%b busy=%b exp=%b busy=0", obs, div_busy, NONE); end
  endtask

  task automatic test_load_use();
    cyc();
    load_use = 1'b1;
    @(negedge clk);
    checks++; if (obs !== LU) begin errors++; $display("FAIL load_use got=%b exp=%b", obs, LU); end
    cyc();
    load_use = 1'b0;
    @(negedge clk);
    checks++; if (obs !== NONE) begin errors++; $display("FAIL load_use_clear got=%b exp=%b", obs, NONE); end
  endtask

  task automatic test_div();
    cyc();
    div_start_EX = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      checks++; if (stall_EX !== (k < 15)) begin errors++; $display("FAIL div_stall_ex t%0d got=%b exp=%b", k, stall_EX, k < 15); end
      checks++; if (div_done !== (k == 15)) begin errors++; $display("FAIL div_done t%0d got=%b exp=%b", k, div_done, k == 15); end
      checks++; if (div_busy !== (k >= 1)) begin errors++; $display("FAIL div_busy t%0d got=%b exp=%b", k, div_busy, k >= 1); end
      if (k == 0) begin
        checks++; if (obs !== DIVS) begin errors++; $display("FAIL div_issue got=%b exp=%b", obs, DIVS); end
      end
    end
    cyc();
    div_start_EX = 1'b0;
    @(negedge clk);
    checks++; if (obs !== NONE || div_busy !== 1'b0 || div_done !== 1'b0) begin errors++; $display("FAIL div_after got=%b busy=%b done=%b exp=%b 0 0", obs, div_busy, div_done, NONE); end
  endtask

  task automatic test_mem_wait();
    cyc();
    mem_req_MEM = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      mem_ack = (k == 3);
      @(negedge clk);
      checks++; if (obs !== (k < 3 ? MEMS : NONE)) begin errors++; $display("FAIL mem_wait t%0d got=%b exp=%b", k, obs, k < 3 ? MEMS : NONE); end
    end
    cyc();
    mem_req_MEM = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (obs !== NONE) begin errors++; $display("FAIL mem_after got=%b exp=%b", obs, NONE); end
    cyc();
    mem_req_MEM = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (obs !== NONE) begin errors++; $display("FAIL mem_same_ack got=%b exp=%b", obs, NONE); end
    cyc();
    mem_req_MEM = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (obs !== NONE) begin errors++; $display("FAIL mem_no_entry got=%b exp=%b", obs, NONE); end
  endtask

  task automatic test_branch_load_use();
    cyc();
    br_taken_EX = 1'b1;
    load_use = 1'b1;
    @(negedge clk);
    checks++; if (obs !== BR) begin errors++; $display("FAIL br_lu got=%b exp=%b", obs, BR); end
    checks++; if (stall_IF !== 1'b0) begin errors++; $display("FAIL br_lu_stall_if got=%b exp=0", stall_IF); end
    cyc();
    br_taken_EX = 1'b0;
    load_use = 1'b0;
    @(negedge clk);
    checks++; if (obs !== NONE) begin errors++; $display("FAIL br_lu_clear got=%b exp=%b", obs, NONE); end
  endtask

  task automatic test_branch_mem_wait();
    int n = 0;
    cyc();
    mem_req_MEM = 1'b1;
    br_taken_EX = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      mem_ack = (k == 2);
      @(negedge clk);
      n += int'(redirect);
      checks++; if (obs !== (k < 2 ? MEMS : BR)) begin errors++; $display("FAIL br_mem t%0d got=%b exp=%b", k, obs, k < 2 ? MEMS : BR); end
    end
    cyc();
    br_taken_EX = 1'b0;
    mem_req_MEM = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    n += int'(redirect);
    checks++; if (n !== 1) begin errors++; $display("FAIL br_mem_once got=%0d exp=1", n); end
  endtask

  task automatic test_div_deferred();
    cyc();
    mem_req_MEM = 1'b1;
    div_start_EX = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      mem_ack = (k == 2);
      @(negedge clk);
      checks++; if (obs !== (k < 2 ? MEMS : DIVS)) begin errors++; $display("FAIL div_defer t%0d got=%b exp=%b", k, obs, k < 2 ? MEMS : DIVS); end
      checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_defer_busy t%0d got=%b exp=0", k, div_busy); end
    end
    cyc();
    mem_req_MEM = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (div_busy !== 1'b1 || obs !== DIVS) begin errors++; $display("FAIL div_defer_start busy=%b got=%b exp=1 %b", div_busy, obs, DIVS); end
    rstn = 1'b0;
    div_start_EX = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset_mid_div();
    logic seen = 1'b0;
    cyc();
    div_start_EX = 1'b1;
    for (int k = 1; k <= 10; k++) cyc();
    @(negedge clk);
    checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL rst_div_pre got=%b exp=1", div_busy); end
    rstn = 1'b0;
    div_start_EX = 1'b0;
    #1;
    checks++; if (div_busy !== 1'b0 || div_done !== 1'b0) begin errors++; $display("FAIL rst_div_abort busy=%b done=%b exp=0 0", div_busy, div_done); end
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      seen = seen | div_done | div_busy;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_perf();
    load_use = 1'b1;
    cyc();
    cyc();
    cyc();
    load_use = 1'b0;
    br_taken_EX = 1'b1;
    cyc();
    br_taken_EX = 1'b0;
    @(negedge clk);
    checks++; if (stall_cycles !== EXP_STALLS) begin errors++; $display("FAIL perf_stalls got=%0d exp=%0d", stall_cycles, EXP_STALLS); end
    checks++; if (flush_count !== EXP_FLUSHES) begin errors++; $display("FAIL perf_flushes got=%0d exp=%0d", flush_count, EXP_FLUSHES); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div();
    test_mem_wait();
    test_branch_load_use();
    test_branch_mem_wait();
    test_div_deferred();
    test_reset_mid_div();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
